// File: rtl/pipelined_control_unit_if.sv
// ID-stage request and pipelined control-bundle signals of the control unit.
// master drives the ID inputs (fetch/hazard side); slave is the control unit.
interface pipelined_control_unit_if #(
  parameter int unsigned OP_W  = 5,
  parameter int unsigned FN_W  = 5,
  parameter int unsigned CNT_W = 4
);
  logic            in_valid;
  logic [OP_W-1:0] Op;
  logic [FN_W-1:0] funct5;
  logic            stall;
  logic            flush;

  logic            ex_valid;
  logic            ex_RegWrite;
  logic            ex_ALUSrc;
  logic            ex_MemWrite;
  logic            ex_ResultSrc;
  logic            ex_Branch;
  logic            ex_Jump;
  logic            ex_Call;
  logic            ex_Ret;
  logic [1:0]      ex_ImmSrc;
  logic [FN_W-1:0] ex_ALUControl;

  logic            mem_valid;
  logic            mem_RegWrite;
  logic            mem_MemWrite;
  logic            mem_ResultSrc;

  logic            wb_valid;
  logic            wb_RegWrite;
  logic            wb_ResultSrc;

  logic             illegal_op;
  logic [CNT_W-1:0] ras_depth;
  logic             ras_full;
  logic             ras_empty;
  logic             ras_overflow;
  logic             ras_underflow;

  modport master (
    output in_valid, Op, funct5, stall, flush,
    input  ex_valid, ex_RegWrite, ex_ALUSrc, ex_MemWrite, ex_ResultSrc, ex_Branch, ex_Jump,
           ex_Call, ex_Ret, ex_ImmSrc, ex_ALUControl,
           mem_valid, mem_RegWrite, mem_MemWrite, mem_ResultSrc,
           wb_valid, wb_RegWrite, wb_ResultSrc,
           illegal_op, ras_depth, ras_full, ras_empty, ras_overflow, ras_underflow
  );

  modport slave (
    input  in_valid, Op, funct5, stall, flush,
    output ex_valid, ex_RegWrite, ex_ALUSrc, ex_MemWrite, ex_ResultSrc, ex_Branch, ex_Jump,
           ex_Call, ex_Ret, ex_ImmSrc, ex_ALUControl,
           mem_valid, mem_RegWrite, mem_MemWrite, mem_ResultSrc,
           wb_valid, wb_RegWrite, wb_ResultSrc,
           illegal_op, ras_depth, ras_full, ras_empty, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// Pipelined control decoder: decodes in ID, carries the control bundle through
// ID/EX, EX/MEM and MEM/WB, and tracks call/return depth against the return stack.
module pipelined_control_unit #(
  parameter int unsigned OP_W      = 5,
  parameter int unsigned FN_W      = 5,
  parameter int unsigned RAS_DEPTH = 8,
  parameter int unsigned CNT_W     = $clog2(RAS_DEPTH + 1)
) (
  input logic                    clk,
  input logic                    rst,
  pipelined_control_unit_if.slave bus
);

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            alu_src;
    logic            mem_write;
    logic            result_src;
    logic            branch;
    logic            jump;
    logic            call;
    logic            ret;
    logic [1:0]      imm_src;
    logic [FN_W-1:0] alu_ctrl;
  } ctrl_t;

  localparam logic [CNT_W-1:0] DepthMax = CNT_W'(RAS_DEPTH);

  ctrl_t            dec;
  logic             legal;
  logic [1:0]       alu_op;
  logic             issue;

  ctrl_t            ex_q, ex_d;
  logic             mem_valid_q, mem_reg_write_q, mem_mem_write_q, mem_result_src_q;
  logic             wb_valid_q, wb_reg_write_q, wb_result_src_q;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] depth_q, depth_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  always_comb begin
    dec    = '0;
    legal  = 1'b1;
    alu_op = 2'b00;
    case (bus.Op)
      OP_W'(0): begin dec.reg_write = 1'b1; alu_op = 2'b10; end
      OP_W'(1): begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; alu_op = 2'b10; end
      OP_W'(2): begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.result_src = 1'b1; end
      OP_W'(3): begin dec.alu_src = 1'b1; dec.mem_write = 1'b1; dec.imm_src = 2'b01; end
      OP_W'(4): begin dec.branch = 1'b1; dec.imm_src = 2'b10; alu_op = 2'b01; end
      OP_W'(5): begin dec.jump = 1'b1; dec.imm_src = 2'b11; end
      OP_W'(6): begin
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
        dec.call      = 1'b1;
        dec.imm_src   = 2'b11;
      end
      OP_W'(7): begin dec.jump = 1'b1; dec.ret = 1'b1; end
      default:  legal = 1'b0;
    endcase
    case (alu_op)
      2'b01:   dec.alu_ctrl = FN_W'(1);
      2'b10:   dec.alu_ctrl = bus.funct5;
      default: dec.alu_ctrl = '0;
    endcase
    dec.valid = legal;
  end

  // flush and stall both turn the slot into a bubble; illegal ops never issue
  assign issue = bus.in_valid & ~bus.stall & ~bus.flush & legal;

  always_comb begin
    ex_d      = issue ? dec : '0;
    illegal_d = illegal_q | (bus.in_valid & ~bus.stall & ~bus.flush & ~legal);
    depth_d   = depth_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    if (issue && dec.call) begin
      if (depth_q == DepthMax) ovf_d = 1'b1;
      else                     depth_d = depth_q + 1'b1;
    end
    if (issue && dec.ret) begin
      if (depth_q == '0) udf_d = 1'b1;
      else               depth_d = depth_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q             <= '0;
      mem_valid_q      <= 1'b0;
      mem_reg_write_q  <= 1'b0;
      mem_mem_write_q  <= 1'b0;
      mem_result_src_q <= 1'b0;
      wb_valid_q       <= 1'b0;
      wb_reg_write_q   <= 1'b0;
      wb_result_src_q  <= 1'b0;
      illegal_q        <= 1'b0;
      depth_q          <= '0;
      ovf_q            <= 1'b0;
      udf_q            <= 1'b0;
    end else begin
      ex_q             <= ex_d;
      mem_valid_q      <= ex_q.valid;
      mem_reg_write_q  <= ex_q.reg_write;
      mem_mem_write_q  <= ex_q.mem_write;
      mem_result_src_q <= ex_q.result_src;
      wb_valid_q       <= mem_valid_q;
      wb_reg_write_q   <= mem_reg_write_q;
      wb_result_src_q  <= mem_result_src_q;
      illegal_q        <= illegal_d;
      depth_q          <= depth_d;
      ovf_q            <= ovf_d;
      udf_q            <= udf_d;
    end
  end

  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_RegWrite   = ex_q.reg_write;
  assign bus.ex_ALUSrc     = ex_q.alu_src;
  assign bus.ex_MemWrite   = ex_q.mem_write;
  assign bus.ex_ResultSrc  = ex_q.result_src;
  assign bus.ex_Branch     = ex_q.branch;
  assign bus.ex_Jump       = ex_q.jump;
  assign bus.ex_Call       = ex_q.call;
  assign bus.ex_Ret        = ex_q.ret;
  assign bus.ex_ImmSrc     = ex_q.imm_src;
  assign bus.ex_ALUControl = ex_q.alu_ctrl;

  assign bus.mem_valid     = mem_valid_q;
  assign bus.mem_RegWrite  = mem_reg_write_q;
  assign bus.mem_MemWrite  = mem_mem_write_q;
  assign bus.mem_ResultSrc = mem_result_src_q;

  assign bus.wb_valid      = wb_valid_q;
  assign bus.wb_RegWrite   = wb_reg_write_q;
  assign bus.wb_ResultSrc  = wb_result_src_q;

  assign bus.illegal_op    = illegal_q;
  assign bus.ras_depth     = depth_q;
  assign bus.ras_full      = (depth_q == DepthMax);
  assign bus.ras_empty     = (depth_q == '0);
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = udf_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed plus randomized bench for pipelined_control_unit against a
// table-driven reference model of decode, pipeline latency and call depth.
module tb_pipelined_control_unit;

  localparam int RD = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_control_unit_if #(.OP_W(5), .FN_W(5), .CNT_W(4)) bus ();

  pipelined_control_unit #(.OP_W(5), .FN_W(5), .RAS_DEPTH(RD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic v, rw, as, mw, rs, br, j, c, r;
    logic [1:0] imm;
    logic [4:0] alu;
  } b_t;

  b_t m_ex, m_mem, m_wb;
  int m_depth;
  bit m_ill, m_ovf, m_udf;
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Fields in table order: RegWrite ALUSrc MemWrite ResultSrc Branch Jump Call Ret ImmSrc ALUOp
  function automatic b_t ref_decode(input logic [4:0] op, input logic [4:0] fn);
    logic [11:0] f;
    b_t b;
    b = '0;
    case (op)
      5'd0: f = 12'b1_0_0_0_0_0_0_0_00_10;
      5'd1: f = 12'b1_1_0_0_0_0_0_0_00_10;
      5'd2: f = 12'b1_1_0_1_0_0_0_0_00_00;
      5'd3: f = 12'b0_1_1_0_0_0_0_0_01_00;
      5'd4: f = 12'b0_0_0_0_1_0_0_0_10_01;
      5'd5: f = 12'b0_0_0_0_0_1_0_0_11_00;
      5'd6: f = 12'b1_0_0_0_0_1_1_0_11_00;
      5'd7: f = 12'b0_0_0_0_0_1_0_1_00_00;
      default: return b;
    endcase
    b.v = 1'b1;
    {b.rw, b.as, b.mw, b.rs, b.br, b.j, b.c, b.r, b.imm} = f[11:2];
    case (f[1:0])
      2'b01:   b.alu = 5'd1;
      2'b10:   b.alu = fn;
      default: b.alu = 5'd0;
    endcase
    return b;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".ex"}, {bus.ex_valid, bus.ex_RegWrite, bus.ex_ALUSrc, bus.ex_MemWrite,
        bus.ex_ResultSrc, bus.ex_Branch, bus.ex_Jump, bus.ex_Call, bus.ex_Ret,
        bus.ex_ImmSrc, bus.ex_ALUControl}, m_ex);
    chk({tag, ".mem"}, {bus.mem_valid, bus.mem_RegWrite, bus.mem_MemWrite, bus.mem_ResultSrc},
        {m_mem.v, m_mem.rw, m_mem.mw, m_mem.rs});
    chk({tag, ".wb"}, {bus.wb_valid, bus.wb_RegWrite, bus.wb_ResultSrc},
        {m_wb.v, m_wb.rw, m_wb.rs});
    chk({tag, ".flags"}, {bus.illegal_op, bus.ras_depth, bus.ras_full, bus.ras_empty,
        bus.ras_overflow, bus.ras_underflow},
        {m_ill, 4'(m_depth), m_depth == RD, m_depth == 0, m_ovf, m_udf});
  endtask

  // Apply one cycle of inputs, advance the model, then compare everything.
  task automatic step(input string tag, input bit v, input logic [4:0] op, input logic [4:0] fn,
                      input bit st, input bit fl, input bit r);
    b_t d;
    bit go;
    bus.in_valid = v;
    bus.Op       = op;
    bus.funct5   = fn;
    bus.stall    = st;
    bus.flush    = fl;
    rst          = r;
    @(posedge clk);
    #1;
    if (r) begin
      m_ex = '0; m_mem = '0; m_wb = '0;
      m_depth = 0; m_ill = 0; m_ovf = 0; m_udf = 0;
    end else begin
      d  = ref_decode(op, fn);
      go = v && !st && !fl;
      m_wb  = m_mem;
      m_mem = m_ex;
      if (go && !d.v) m_ill = 1;
      if (go && d.c) begin
        if (m_depth == RD) m_ovf = 1;
        else m_depth++;
      end
      if (go && d.r) begin
        if (m_depth == 0) m_udf = 1;
        else m_depth--;
      end
      m_ex = (go && d.v) ? d : '0;
    end
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 5'd0, 5'd0, 0, 0, 0);
  endtask

  initial begin
    bus.in_valid = 0; bus.Op = '0; bus.funct5 = '0; bus.stall = 0; bus.flush = 0; rst = 1;
    step("reset0", 0, 5'd0, 5'd0, 0, 0, 1);
    step("reset1", 1, 5'd2, 5'd0, 1, 1, 1);
    chk("reset_empty", bus.ras_empty, 1);
    chk("reset_full", bus.ras_full, 0);

    step("load", 1, 5'd2, 5'd0, 0, 0, 0);
    chk("load_ex_valid", bus.ex_valid, 1);
    chk("load_ex_resultsrc", bus.ex_ResultSrc, 1);
    chk("load_ex_aluctl", bus.ex_ALUControl, 0);
    idle("load_mem");
    chk("load_mem_resultsrc", bus.mem_ResultSrc, 1);
    idle("load_wb");
    chk("load_wb_regwrite", bus.wb_RegWrite, 1);
    chk("load_wb_resultsrc", bus.wb_ResultSrc, 1);

    step("rtype_stall0", 1, 5'd0, 5'd6, 1, 0, 0);
    chk("stall0_ex_valid", bus.ex_valid, 0);
    step("rtype_stall1", 1, 5'd0, 5'd6, 1, 0, 0);
    chk("stall1_ex_valid", bus.ex_valid, 0);
    step("rtype_go", 1, 5'd0, 5'd6, 0, 0, 0);
    chk("rtype_aluctl", bus.ex_ALUControl, 5'b00110);
    chk("rtype_ex_valid", bus.ex_valid, 1);
    idle("rtype_after");
    chk("rtype_once", bus.ex_valid, 0);

    step("call_flush", 1, 5'd6, 5'd0, 1, 1, 0);
    chk("call_flush_depth", bus.ras_depth, 0);
    step("call", 1, 5'd6, 5'd0, 0, 0, 0);
    chk("call_depth", bus.ras_depth, 1);
    chk("call_bits", {bus.ex_Call, bus.ex_Jump, bus.ex_RegWrite}, 3'b111);

    step("rst_mid", 0, 5'd0, 5'd0, 0, 0, 1);
    for (int i = 0; i < 9; i++) step("calls", 1, 5'd6, 5'(i), 0, 0, 0);
    chk("calls_depth", bus.ras_depth, 8);
    chk("calls_full_ovf", {bus.ras_full, bus.ras_overflow}, 2'b11);
    for (int i = 0; i < 9; i++) step("rets", 1, 5'd7, 5'(i), 0, 0, 0);
    chk("rets_depth", bus.ras_depth, 0);
    chk("rets_empty_udf", {bus.ras_empty, bus.ras_underflow}, 2'b11);

    step("illegal", 1, 5'd31, 5'd3, 0, 0, 0);
    chk("illegal_ex_valid", bus.ex_valid, 0);
    chk("illegal_flag", bus.illegal_op, 1);
    idle("illegal_hold");
    chk("illegal_held", bus.illegal_op, 1);
    step("pre_rst_a", 1, 5'd6, 5'd0, 0, 0, 0);
    step("pre_rst_b", 1, 5'd2, 5'd0, 0, 0, 0);
    step("rst_flight", 1, 5'd1, 5'd0, 0, 0, 1);
    chk("rst_valids", {bus.ex_valid, bus.mem_valid, bus.wb_valid}, 3'b000);
    chk("rst_ill_depth", {bus.illegal_op, bus.ras_depth}, 5'd0);

    for (int i = 0; i < 400; i++) begin
      logic [4:0] op;
      op = 5'($urandom_range(0, 9));
      if (op > 5'd7) op = 5'($urandom_range(8, 31));
      step("rand", ($urandom % 8) != 0, op, 5'($urandom), ($urandom % 5) == 0,
           ($urandom % 7) == 0, ($urandom % 60) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Parametrised, pipelined successor to the combinational control decoder of the 19-bit CPU.
- Decodes Op/funct5 in ID and registers the control bundle through ID/EX, EX/MEM and MEM/WB.
- Supports hazard stall and flush.
- Tracks call/return nesting depth against the hardware return-stack capacity, and flags illegal opcodes and stack faults.

Parameters:
- OP_W, 5, opcode width.
- FN_W, 5, funct field width; also the ALUControl width.
- RAS_DEPTH, 8, return-stack capacity in entries; must be ≥ 2.
- CNT_W, $clog2(RAS_DEPTH+1), depth-counter width (derived).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ID holds a valid instruction.
- Op  in  OP_W  opcode.
- funct5  in  FN_W  function field.
- stall  in  1  hazard unit: hold ID, inject bubble into ID/EX.
- flush  in  1  branch/jump taken in EX: kill the ID/EX entry.
- ex_valid, ex_RegWrite, ex_ALUSrc, ex_MemWrite, ex_ResultSrc, ex_Branch, ex_Jump, ex_Call, ex_Ret  out  1 each  ID/EX control bits.
- ex_ImmSrc  out  2  ID/EX immediate select.
- ex_ALUControl  out  FN_W  ID/EX ALU operation.
- mem_valid, mem_RegWrite, mem_MemWrite, mem_ResultSrc  out  1 each  EX/MEM control bits.
- wb_valid, wb_RegWrite, wb_ResultSrc  out  1 each  MEM/WB control bits.
- illegal_op  out  1  sticky: an undefined opcode was issued.
- ras_depth  out  CNT_W  current call nesting depth.
- ras_full, ras_empty  out  1 each  depth == RAS_DEPTH / depth == 0.
- ras_overflow, ras_underflow  out  1 each  sticky stack fault flags.

Behaviour:
- Decode (combinational, ID). Fields are RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, Jump, Call, Ret, ImmSrc, ALUOp:
  - 00000 R-type: 1,0,0,0,0,0,0,0,ImmSrc 00, ALUOp 10
  - 00001 I-ALU: 1,1,0,0,0,0,0,0,00,10
  - 00010 LOAD: 1,1,0,1,0,0,0,0,00,00
  - 00011 STORE: 0,1,1,0,0,0,0,0,01,00
  - 00100 BRANCH: 0,0,0,0,1,0,0,0,10,01
  - 00101 JUMP: 0,0,0,0,0,1,0,0,11,00
  - 00110 CALL: 1,0,0,0,0,1,1,0,11,00
  - 00111 RET: 0,0,0,0,0,1,0,1,00,00
  - Any other opcode: all zero; the instruction is illegal.
- ALUControl derivation:
  - ALUOp 00 → all zeros (add).
  - ALUOp 01 → 1 zero-extended to FN_W (sub).
  - ALUOp 10 → funct5.
- Issue condition: issue = in_valid & ~stall & ~flush & legal.
- ID/EX register, every cycle:
  - issue: load the decoded bundle, ex_valid=1.
  - otherwise: load all zeros (bubble), ex_valid=0.
  - flush takes priority over stall; both clear.
- EX/MEM and MEM/WB advance unconditionally every cycle. The stall does not freeze downstream stages.
  - mem_* ← ex_* equivalents.
  - wb_* ← mem_* equivalents.
  - Latency: decode at cycle N → ex_* at N+1, mem_* at N+2, wb_* at N+3.
- Illegal opcodes:
  - Condition: in_valid & ~stall & ~flush & illegal sets illegal_op (sticky until rst).
  - The slot becomes a bubble.
- Return-stack depth accounting, counted at issue only:
  - Issued CALL with depth < RAS_DEPTH: depth+1.
  - Issued CALL at depth == RAS_DEPTH: depth unchanged, ras_overflow set (sticky). The instruction still issues.
  - Issued RET with depth > 0: depth-1.
  - Issued RET at depth 0: depth stays 0, ras_underflow set (sticky). The instruction still issues.
  - Depth never wraps.
  - ras_full and ras_empty are combinational from ras_depth.
- Reset:
  - rst=1 at any edge clears every pipeline register (all valids 0, all control bits 0, ex_ALUControl 0).
  - It also sets ras_depth=0 and clears all sticky flags; ras_empty=1, ras_full=0.
  - rst overrides stall, flush and in_valid in the same cycle. An in-flight instruction is discarded.
- Stalled or flushed CALL/RET do not change the depth. The re-presented instruction counts once, when it finally issues.

Test Plan:
- Reset, then issue LOAD (00010) in cycle 1 → cycle 2: ex_valid=1, RegWrite=1, ALUSrc=1, ResultSrc=1, ALUControl=0; cycle 3: mem_ResultSrc=1; cycle 4: wb_RegWrite=1, wb_ResultSrc=1.
- R-type with funct5=00110, stall=1 for 2 cycles then 0 → two bubbles (ex_valid=0, all zero), then ex_ALUControl=00110, ex_valid=1 once only.
- CALL with flush=1 in the same cycle → ex_valid=0, ras_depth stays 0; next cycle CALL without flush → ras_depth=1, ex_Call=1, ex_Jump=1, ex_RegWrite=1.
- 9 consecutive CALLs with RAS_DEPTH=8 → ras_depth 8, ras_full=1, ras_overflow=1 after the 9th; then 9 RETs → depth 0, ras_empty=1, ras_underflow=1 after the 9th.
- Op=11111 with in_valid=1 → ex_valid=0, illegal_op=1 and held; rst pulse asserted mid-pipeline with valid stages → all valids 0, illegal_op=0, ras_depth=0 on the next cycle.
